demux_1a2_rr: RTL and testbench

- 1:2 demultiplexer for the 8-bit valid/data stream. It is the receive-side counterpart of the 2:1 round-robin mux.
- Each accepted input word is steered alternately to channel 0 then channel 1, restoring the interleave order the mux produced.
- Each channel has a small holding buffer so a paused downstream consumer does not drop data. Upstream is back-pressured through ready_in.

---
 rtl/demux_1a2_rr.sv | 140 ++++++++++++++
 tb/tb_demux_1a2_rr.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1a2_rr.sv
// 1:2 demultiplexer for an 8-bit valid/data stream, with a small FIFO per output channel.
// Words alternate ch0/ch1 by default; define DEMUX_ROUTE_BIT_EN to route each word by data_in[ROUTE_BIT].

module demux_1a2_rr_chan #(
  parameter int BUF_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       push,
  input  logic [7:0] data,
  input  logic       pause,
  output logic       full,
  output logic       valid_out,
  output logic [7:0] data_out
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [BUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          pop;
  logic          wr;

  assign empty = (count == '0);
  assign full  = (count == CW'(BUF_DEPTH));
  assign pop   = !pause && !empty;
  // An arriving word skips the buffer only when the channel is idle and free to emit.
  assign wr    = push && (pause || !empty);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      valid_out <= 1'b0;
      data_out  <= 8'h00;
    end else begin
      valid_out <= 1'b0;
      data_out  <= 8'h00;
      if (!pause) begin
        if (!empty) begin
          valid_out <= 1'b1;
          data_out  <= mem[rd_ptr];
        end else if (push) begin
          valid_out <= 1'b1;
          data_out  <= data;
        end
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (wr)  wr_ptr <= wr_ptr + PW'(1);
      count <= count + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= data;
  end

endmodule

module demux_1a2_rr #(
  parameter int BUF_DEPTH = 2,
  parameter int ROUTE_BIT = 7
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic       ready_in,
  input  logic       pause_0,
  input  logic       pause_1,
  output logic       valid_out_0,
  output logic [7:0] data_out_0,
  output logic       valid_out_1,
  output logic [7:0] data_out_1
);

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BUF_DEPTH must be a power of 2 and at least 2");
  end
  if (ROUTE_BIT < 0 || ROUTE_BIT > 7) begin : g_bad_route_bit
    $error("ROUTE_BIT must index the 8-bit data word");
  end

  logic selector;
  logic tgt;
  logic full_0;
  logic full_1;
  logic accept;
  logic push_0;
  logic push_1;

`ifdef DEMUX_ROUTE_BIT_EN
  assign tgt = data_in[ROUTE_BIT];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) selector <= 1'b0;
    else          selector <= selector;
  end
`else
  assign tgt = selector;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)    selector <= 1'b0;
    else if (accept) selector <= ~selector;
  end
`endif

  assign ready_in = reset_L && !(tgt ? full_1 : full_0);
  assign accept   = valid_in && ready_in;
  assign push_0   = accept && !tgt;
  assign push_1   = accept && tgt;

  demux_1a2_rr_chan #(.BUF_DEPTH(BUF_DEPTH)) u_ch0 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push_0),
    .data      (data_in),
    .pause     (pause_0),
    .full      (full_0),
    .valid_out (valid_out_0),
    .data_out  (data_out_0)
  );

  demux_1a2_rr_chan #(.BUF_DEPTH(BUF_DEPTH)) u_ch1 (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (push_1),
    .data      (data_in),
    .pause     (pause_1),
    .full      (full_1),
    .valid_out (valid_out_1),
    .data_out  (data_out_1)
  );

endmodule

// File: tb/tb_demux_1a2_rr.sv
// Scoreboard bench for demux_1a2_rr: a queue-based reference model predicts each cycle's
// outputs and ready_in; a separate monitor compares the registered outputs on the falling edge.

module tb_demux_1a2_rr;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready_in;
  logic       pause_0 = 1'b0;
  logic       pause_1 = 1'b0;
  logic       valid_out_0;
  logic [7:0] data_out_0;
  logic       valid_out_1;
  logic [7:0] data_out_1;

  demux_1a2_rr #(.BUF_DEPTH(DEPTH), .ROUTE_BIT(7)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_in    (ready_in),
    .pause_0     (pause_0),
    .pause_1     (pause_1),
    .valid_out_0 (valid_out_0),
    .data_out_0  (data_out_0),
    .valid_out_1 (valid_out_1),
    .data_out_1  (data_out_1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic       msel = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_tgt(input logic [7:0] d);
`ifdef DEMUX_ROUTE_BIT_EN
    return d[7];
`else
    return msel;
`endif
  endfunction

  function automatic logic model_ready(input logic [7:0] d);
    if (model_tgt(d)) return mq1.size() < DEPTH;
    return mq0.size() < DEPTH;
  endfunction

  // One clock edge of the reference: each channel emits its oldest waiting word, or the new word directly if idle.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic p0, input logic p1);
    exp_t e;
    logic acc;
    logic t;
    acc = v && model_ready(d);
    t   = model_tgt(d);
    e   = '{1'b0, 8'h00, 1'b0, 8'h00};
    if (p0) begin
      if (acc && !t) mq0.push_back(d);
    end else if (mq0.size() > 0) begin
      e.v0 = 1'b1;
      e.d0 = mq0.pop_front();
      if (acc && !t) mq0.push_back(d);
    end else if (acc && !t) begin
      e.v0 = 1'b1;
      e.d0 = d;
    end
    if (p1) begin
      if (acc && t) mq1.push_back(d);
    end else if (mq1.size() > 0) begin
      e.v1 = 1'b1;
      e.d1 = mq1.pop_front();
      if (acc && t) mq1.push_back(d);
    end else if (acc && t) begin
      e.v1 = 1'b1;
      e.d1 = d;
    end
`ifndef DEMUX_ROUTE_BIT_EN
    if (acc) msel = ~msel;
`endif
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the next one with the model advanced.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic p0, input logic p1,
                               output logic accepted);
    logic exp_ready;
    valid_in = v;
    data_in  = d;
    pause_0  = p0;
    pause_1  = p1;
    #1;
    exp_ready = model_ready(d);
    check("ready_in", int'(ready_in), int'(exp_ready));
    accepted = v && exp_ready;
    @(posedge clk);
    #1;
    model_edge(v, d, p0, p1);
  endtask

  task automatic pulseReset();
    #2 reset_L = 1'b0;
    #1;
    sb.delete();
    mq0.delete();
    mq1.delete();
    msel = 1'b0;
    check("rst_valid_out_0", int'(valid_out_0), 0);
    check("rst_data_out_0", int'(data_out_0), 0);
    check("rst_valid_out_1", int'(valid_out_1), 0);
    check("rst_data_out_1", int'(data_out_1), 0);
    check("rst_ready_in", int'(ready_in), 0);
    @(posedge clk);
    #1;
    check("rst_hold_valid_out_0", int'(valid_out_0), 0);
    check("rst_hold_valid_out_1", int'(valid_out_1), 0);
    reset_L = 1'b1;
  endtask

  // Monitor: consumes one predicted output set per cycle, independent of the stimulus process.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("valid_out_0", int'(valid_out_0), int'(e.v0));
      check("data_out_0", int'(data_out_0), int'(e.d0));
      check("valid_out_1", int'(valid_out_1), int'(e.v1));
      check("data_out_1", int'(data_out_1), int'(e.d1));
    end
  endtask

  always @(negedge clk) checkOutput();

  initial begin
    logic       acc;
    logic       v;
    logic [7:0] d;
    logic       pending;

    #1;
    check("reset_ready_in", int'(ready_in), 0);
    check("reset_valid_out_0", int'(valid_out_0), 0);
    check("reset_valid_out_1", int'(valid_out_1), 0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 8'h14, 1'b1, 1'b0, acc);
    check("stall_on_full_ch0", int'(acc), 0);
    applyStimulus(1'b1, 8'h14, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 8'h14, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b1, 1'b1, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h24, 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h24, 1'b0, 1'b0, acc);

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b1, 1'b1, acc);
    pulseReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, acc);

    pending = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (!pending) begin
        v = ($urandom_range(0, 9) < 7);
        d = 8'($urandom);
      end else begin
        v = 1'b1;
      end
      applyStimulus(v, d, ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4), acc);
      pending = v && !acc;
      if (i == 200) pulseReset();
      if (i == 200) pending = 1'b0;
    end

    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("model_drained", int'(mq0.size() + mq1.size()), 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
